// File: rtl/multififo_drain_stage_if.sv
// Bundle between the multififo head, the drain stage and its downstream consumer.
// slave: the drain stage itself. master: the side that drives the multififo head
// and the downstream controls (the testbench or the surrounding pipeline).
interface multififo_drain_stage_if #(
  parameter int PORT_NUM = 4,
  parameter int WIDTH    = 32
);
  localparam int CW = $clog2(PORT_NUM) + 1;

  // multififo head side
  logic [WIDTH-1:0]    fifo_data_out [0:PORT_NUM-1];
  logic [PORT_NUM-1:0] fifo_data_out_valid;
  logic [PORT_NUM-1:0] fifo_data_pop_valid;
  logic                fifo_pop;

  // issue control and downstream side
  logic [CW-1:0]       issue_limit;
  logic                downstream_stall;
  logic                flush;
  logic [WIDTH-1:0]    out_data [0:PORT_NUM-1];
  logic [PORT_NUM-1:0] out_valid;

  modport slave (
    input  fifo_data_out, fifo_data_out_valid, issue_limit, downstream_stall, flush,
    output fifo_data_pop_valid, fifo_pop, out_data, out_valid
  );

  modport master (
    output fifo_data_out, fifo_data_out_valid, issue_limit, downstream_stall, flush,
    input  fifo_data_pop_valid, fifo_pop, out_data, out_valid
  );
endinterface

// File: rtl/multififo_drain_stage.sv
// Drains a contiguous prefix of multififo lanes (up to issue_limit) into a registered output stage.
// Latency: one cycle from pop to out_*; full throughput of PORT_NUM lanes per cycle when not stalled.
// Backpressure: downstream_stall holds a non-empty register and suppresses pops; flush clears it.
// Optional: define DRAIN_STAGE_PERF_COUNTER_EN to add issued_count / stall_count ports.
module multififo_drain_stage #(
  parameter int PORT_NUM = 4,
  parameter int WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  multififo_drain_stage_if.slave bus
`ifdef DRAIN_STAGE_PERF_COUNTER_EN
  ,
  output logic [31:0]           issued_count,
  output logic [31:0]           stall_count
`endif
);

  localparam int CW = $clog2(PORT_NUM) + 1;

  logic [CW-1:0]       prefix_cnt;
  logic [CW-1:0]       limit_clamped;
  logic [CW-1:0]       take_cnt;
  logic [PORT_NUM-1:0] take_mask;
  logic                load_en;
  logic                pop_en;
  logic                prefix_run;

  logic [WIDTH-1:0]    out_data_q [0:PORT_NUM-1];
  logic [PORT_NUM-1:0] out_valid_q;

  // Count leading valid lanes from lane 0; a hole ends the run so later valids are ignored.
  always_comb begin
    prefix_cnt = '0;
    prefix_run = 1'b1;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (prefix_run && bus.fifo_data_out_valid[i]) begin
        prefix_cnt = prefix_cnt + CW'(1);
      end else begin
        prefix_run = 1'b0;
      end
    end
  end

  // Take count is the prefix length capped by issue_limit, itself capped at PORT_NUM.
  always_comb begin
    limit_clamped = (bus.issue_limit > CW'(PORT_NUM)) ? CW'(PORT_NUM) : bus.issue_limit;
    take_cnt      = (prefix_cnt < limit_clamped) ? prefix_cnt : limit_clamped;
    take_mask     = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      take_mask[i] = (i < int'(take_cnt));
    end
  end

  // The register accepts new data when it is empty or is being consumed this edge.
  assign load_en = (out_valid_q == '0) || !bus.downstream_stall;

  // Pops are suppressed while flushing and while reset holds the register empty.
  assign pop_en = load_en && !bus.flush && !rst;

  assign bus.fifo_data_pop_valid = pop_en ? take_mask : '0;
  assign bus.fifo_pop            = pop_en && (take_cnt != '0);

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Output register: flush beats load; a stalled non-empty register holds its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        out_data_q[i] <= '0;
      end
    end else if (bus.flush) begin
      out_valid_q <= '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        out_data_q[i] <= '0;
      end
    end else if (load_en) begin
      out_valid_q <= take_mask;
      for (int i = 0; i < PORT_NUM; i++) begin
        out_data_q[i] <= take_mask[i] ? bus.fifo_data_out[i] : '0;
      end
    end
  end

`ifdef DRAIN_STAGE_PERF_COUNTER_EN
  function automatic logic [31:0] popcount(input logic [PORT_NUM-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

  // Lanes issued at each consumption edge and edges spent stalled with data; cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_count <= '0;
      stall_count  <= '0;
    end else if (out_valid_q != '0) begin
      if (bus.downstream_stall) begin
        stall_count <= stall_count + 32'd1;
      end else begin
        issued_count <= issued_count + popcount(out_valid_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_multififo_drain_stage.sv
// Self-checking bench for multififo_drain_stage at PORT_NUM=4, WIDTH=4: directed vector table,
// hand-written stall / reset sequences, then randomized traffic against a lane-count model.
// Counter checks are active when DRAIN_STAGE_PERF_COUNTER_EN is defined.
module tb_multififo_drain_stage;

  logic clk;
  logic rst;

  multififo_drain_stage_if #(.PORT_NUM(4), .WIDTH(4)) bus ();

`ifdef DRAIN_STAGE_PERF_COUNTER_EN
  logic [31:0] issued_count;
  logic [31:0] stall_count;
`endif

  multififo_drain_stage #(.PORT_NUM(4), .WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DRAIN_STAGE_PERF_COUNTER_EN
    ,
    .issued_count (issued_count),
    .stall_count  (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Driven stimulus (lane 0 data in bits [3:0]).
  logic [3:0]  drv_v;
  logic [15:0] drv_d;
  logic [2:0]  drv_lim;
  logic        drv_st;
  logic        drv_fl;

  // Reference model: number of valid lanes held, their data, and the counters.
  int          m_cnt;
  logic [3:0]  m_dat [4];
  logic [31:0] m_iss;
  logic [31:0] m_stl;
  logic [3:0]  obs_pop;

  typedef struct {
    logic [3:0]  v;
    logic [15:0] d;
    logic [2:0]  lim;
    logic        stall;
    logic        flush;
    logic [3:0]  e_pop;
    logic [3:0]  e_ov;
    logic [15:0] e_od;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lmask(input int n);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (i < n) r[i] = 1'b1;
    return r;
  endfunction

  // Lanes taken: length of the leading run of valids, limited by min(issue_limit, 4).
  function automatic int take_n(input logic [3:0] v, input logic [2:0] lim);
    int p;
    int l;
    p = 0;
    while (p < 4 && v[p]) p++;
    l = (lim > 3'd4) ? 4 : int'(lim);
    return (p < l) ? p : l;
  endfunction

  function automatic logic [15:0] out_packed();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = bus.out_data[i];
    return r;
  endfunction

  function automatic logic [15:0] model_packed();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = m_dat[i];
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_iss = '0;
    m_stl = '0;
    for (int i = 0; i < 4; i++) m_dat[i] = '0;
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] d, input logic [2:0] lim,
                       input logic st, input logic fl);
    drv_v = v; drv_d = d; drv_lim = lim; drv_st = st; drv_fl = fl;
    bus.fifo_data_out_valid = v;
    for (int i = 0; i < 4; i++) bus.fifo_data_out[i] = d[i*4 +: 4];
    bus.issue_limit      = lim;
    bus.downstream_stall = st;
    bus.flush            = fl;
  endtask

  // Called at posedge+1 with inputs driven; checks the pop mid-cycle, steps the model across
  // the edge, then checks the register against the model. Returns at posedge+1.
  task automatic run_cycle();
    int         n;
    logic       le;
    logic [3:0] ep;
    #4;
    n  = take_n(drv_v, drv_lim);
    le = (m_cnt == 0) || !drv_st;
    ep = (le && !drv_fl) ? lmask(n) : 4'b0000;
    obs_pop = bus.fifo_data_pop_valid;
    check("pop_valid", {28'd0, obs_pop}, {28'd0, ep});
    check("fifo_pop", {31'd0, bus.fifo_pop}, {31'd0, (ep != 4'b0000)});
    @(posedge clk);
    #1;
    if (m_cnt != 0 && !drv_st) m_iss = m_iss + 32'(m_cnt);
    if (m_cnt != 0 && drv_st)  m_stl = m_stl + 32'd1;
    if (drv_fl) begin
      m_cnt = 0;
      for (int i = 0; i < 4; i++) m_dat[i] = '0;
    end else if (le) begin
      m_cnt = n;
      for (int i = 0; i < 4; i++) m_dat[i] = (i < n) ? drv_d[i*4 +: 4] : 4'h0;
    end
    check("out_valid", {28'd0, bus.out_valid}, {28'd0, lmask(m_cnt)});
    check("out_data", {16'd0, out_packed()}, {16'd0, model_packed()});
`ifdef DRAIN_STAGE_PERF_COUNTER_EN
    check("issued_count", issued_count, m_iss);
    check("stall_count", stall_count, m_stl);
`endif
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 16'h4321, 3'd4, 1'b0, 1'b0, 4'b1111, 4'b1111, 16'h4321};
    tbl[1]  = '{4'b1011, 16'h8765, 3'd4, 1'b0, 1'b0, 4'b0011, 4'b0011, 16'h0065};
    tbl[2]  = '{4'b1111, 16'hCBA9, 3'd2, 1'b0, 1'b0, 4'b0011, 4'b0011, 16'h00A9};
    tbl[3]  = '{4'b1111, 16'h1111, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000};
    tbl[4]  = '{4'b0111, 16'hF321, 3'd7, 1'b0, 1'b0, 4'b0111, 4'b0111, 16'h0321};
    tbl[5]  = '{4'b1111, 16'h5555, 3'd4, 1'b0, 1'b1, 4'b0000, 4'b0000, 16'h0000};
    tbl[6]  = '{4'b0000, 16'h9999, 3'd4, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000};
    tbl[7]  = '{4'b1110, 16'h1234, 3'd4, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000};
    tbl[8]  = '{4'b0001, 16'h000A, 3'd4, 1'b1, 1'b0, 4'b0001, 4'b0001, 16'h000A};
    tbl[9]  = '{4'b1111, 16'hBBBB, 3'd4, 1'b1, 1'b0, 4'b0000, 4'b0001, 16'h000A};
    tbl[10] = '{4'b0011, 16'h00CD, 3'd1, 1'b0, 1'b0, 4'b0001, 4'b0001, 16'h000D};

    // Reset state, with a full multififo head presented to prove pops stay quiet.
    rst = 1'b1;
    drive(4'b1111, 16'h4321, 3'd4, 1'b0, 1'b0);
    model_reset();
    #12;
    check("rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_packed()}, 32'd0);
    check("rst_pop_valid", {28'd0, bus.fifo_data_pop_valid}, 32'd0);
    check("rst_fifo_pop", {31'd0, bus.fifo_pop}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vector table.
    for (int k = 0; k < 11; k++) begin
      drive(tbl[k].v, tbl[k].d, tbl[k].lim, tbl[k].stall, tbl[k].flush);
      run_cycle();
      check($sformatf("tbl%0d_pop", k), {28'd0, obs_pop}, {28'd0, tbl[k].e_pop});
      check($sformatf("tbl%0d_ov", k), {28'd0, bus.out_valid}, {28'd0, tbl[k].e_ov});
      check($sformatf("tbl%0d_od", k), {16'd0, out_packed()}, {16'd0, tbl[k].e_od});
    end

    // Full register held for three stalled cycles, then consumed and refilled at one edge.
    drive(4'b1111, 16'h4321, 3'd4, 1'b0, 1'b0);
    run_cycle();
    check("stall_fill_ov", {28'd0, bus.out_valid}, 32'h0000000F);
    for (int k = 0; k < 3; k++) begin
      drive(4'b1111, 16'h8765, 3'd4, 1'b1, 1'b0);
      run_cycle();
      check("stall_pop", {28'd0, obs_pop}, 32'd0);
      check("stall_hold_od", {16'd0, out_packed()}, 32'h00004321);
    end
    drive(4'b1111, 16'h8765, 3'd4, 1'b0, 1'b0);
    run_cycle();
    check("release_pop", {28'd0, obs_pop}, 32'h0000000F);
    check("release_od", {16'd0, out_packed()}, 32'h00008765);

    // Asynchronous reset in the middle of a stall.
    drive(4'b1111, 16'hAAAA, 3'd4, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_out_valid", {28'd0, bus.out_valid}, 32'd0);
    check("arst_out_data", {16'd0, out_packed()}, 32'd0);
    check("arst_fifo_pop", {31'd0, bus.fifo_pop}, 32'd0);
`ifdef DRAIN_STAGE_PERF_COUNTER_EN
    check("arst_issued", issued_count, 32'd0);
    check("arst_stall", stall_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'b0111, 16'h0CBA, 3'd4, 1'b0, 1'b0);
    run_cycle();
    check("post_rst_ov", {28'd0, bus.out_valid}, 32'h00000007);
    check("post_rst_od", {16'd0, out_packed()}, 32'h00000CBA);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] v;
      v = ($urandom_range(0, 2) == 0) ? 4'($urandom) : lmask($urandom_range(0, 4));
      drive(v, 16'($urandom), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
